// File: rtl/axi_irc_defs.sv
// ---------------------------------------------------------------------------
// axi_irc_defs
// Definitions shared by the IR/UART RX and TX AXI4-lite control blocks:
//   - register offsets (decoded on addr[3:0])
//   - bit positions inside CTRL, STAT and RXDR
//   - write / read channel FSM state encodings
//   - helper that expands a 4-bit wstrb into a 32-bit byte mask
// ---------------------------------------------------------------------------
package axi_irc_defs;

  // Register offsets
  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_RXDR = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;

  // CTRL fields
  localparam int CTRL_MOD_M_LSB  = 0;
  localparam int CTRL_MOD_M_MSB  = 15;
  localparam int CTRL_DEMOD_BIT  = 16;
  localparam int CTRL_RX_EN_BIT  = 17;
  localparam int CTRL_IRQ_EN_BIT = 18;

  // STAT fields
  localparam int STAT_COUNT_LSB   = 0;
  localparam int STAT_COUNT_MSB   = 8;
  localparam int STAT_EMPTY_BIT   = 16;
  localparam int STAT_FULL_BIT    = 17;
  localparam int STAT_OVERRUN_BIT = 18;

  // RXDR fields
  localparam int RXDR_VALID_BIT = 31;

  // Write channel FSM
  localparam logic [1:0] WRIDLE = 2'd0;
  localparam logic [1:0] WRDATA = 2'd1;
  localparam logic [1:0] WRRESP = 2'd2;

  // Read channel FSM
  localparam logic [0:0] RDIDLE = 1'b0;
  localparam logic [0:0] RDDATA = 1'b1;

  // Expand byte strobes into a bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/irc_rx_fifo.sv
// ---------------------------------------------------------------------------
// irc_rx_fifo
// Synchronous byte FIFO with first-word fall-through: while not empty the
// head byte is presented on dout, and pop simply advances past it.
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset (flushes the FIFO)
//   push, din      write a byte (ignored when full)
//   pop, dout      consume the head byte (ignored when empty)
//   count          occupancy 0..DEPTH
//   empty, full    derived from the registered count
// DEPTH must be a power of two (2..256) so pointers wrap naturally.
// ---------------------------------------------------------------------------
module irc_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == FULL_COUNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage has no reset so it can map onto distributed RAM
  always_ff @(posedge aclk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_ircrx_control.sv
// ---------------------------------------------------------------------------
// axi_ircrx_control
// AXI4-lite control block for the IR/UART receive path. Received bytes arrive
// on an AXI4-stream slave and are buffered in irc_rx_fifo; the CPU reads them
// through RXDR (each read pops one byte), checks STAT, and programs the
// receiver core through CTRL.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_axi_aw*/w*/b*        AXI4-lite write channels (bresp always OKAY)
//   s_axi_ar*/r*           AXI4-lite read channels (rresp always OKAY)
//   s_axis_tready/tdata/tvalid  received byte stream
//   mod_m                  baud divisor (CTRL[15:0])
//   demod_38khz_en         38 kHz demodulator enable (CTRL[16])
//   irq                    only with AXI_IRCRX_IRQ_EN defined
// Optional build macro: AXI_IRCRX_IRQ_EN adds CTRL[18] irq_en and the
// registered irq output = irq_en & (~empty | overrun).
// Only C_DATA_WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module axi_ircrx_control
  import axi_irc_defs::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  input  logic                      s_axi_bready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                      s_axi_arvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  output logic                      s_axis_tready,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic [15:0]               mod_m,
  output logic                      demod_38khz_en
`ifdef AXI_IRCRX_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

`ifdef AXI_IRCRX_IRQ_EN
  localparam logic [31:0] CTRL_WR_MASK = 32'h0007_FFFF;
`else
  localparam logic [31:0] CTRL_WR_MASK = 32'h0003_FFFF;
`endif

  logic [1:0]    r_wstate;
  logic [3:0]    r_waddr;
  logic [0:0]    r_rstate;
  logic [31:0]   r_rdata;
  logic [31:0]   r_ctrl;
  logic          r_overrun;

  logic          w_w_hs;
  logic          w_ar_hs;
  logic [31:0]   w_wmask;
  logic [31:0]   w_rdata_next;
  logic          w_rx_en;
  logic          w_push;
  logic          w_pop;
  logic          w_ovr_set;
  logic          w_ovr_clr;
  logic [7:0]    w_fifo_dout;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_unused;

  // Upper address bits are not decoded
  assign w_unused = ^{s_axi_awaddr[C_ADDR_WIDTH-1:4], s_axi_araddr[C_ADDR_WIDTH-1:4]};

  // ---------------- AXI handshakes ----------------
  assign s_axi_awready = (r_wstate == WRIDLE);
  assign s_axi_wready  = (r_wstate == WRDATA);
  assign s_axi_bvalid  = (r_wstate == WRRESP);
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = (r_rstate == RDIDLE);
  assign s_axi_rvalid  = (r_rstate == RDDATA);
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rdata   = r_rdata;

  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_wmask = strb_mask(s_axi_wstrb);

  // ---------------- Write FSM ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate <= WRIDLE;
      r_waddr  <= '0;
    end else begin
      case (r_wstate)
        WRIDLE: if (s_axi_awvalid) begin
          r_waddr  <= s_axi_awaddr[3:0];
          r_wstate <= WRDATA;
        end
        WRDATA: if (s_axi_wvalid) r_wstate <= WRRESP;
        WRRESP: if (s_axi_bready) r_wstate <= WRIDLE;
        default: r_wstate <= WRIDLE;
      endcase
    end
  end

  // CTRL: non-implemented bits are masked so they always read back as 0
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ctrl <= '0;
    end else if (w_w_hs && (r_waddr == ADDR_CTRL)) begin
      r_ctrl <= ((r_ctrl & ~w_wmask) | (s_axi_wdata & w_wmask)) & CTRL_WR_MASK;
    end
  end

  assign mod_m          = r_ctrl[CTRL_MOD_M_MSB:CTRL_MOD_M_LSB];
  assign demod_38khz_en = r_ctrl[CTRL_DEMOD_BIT];
  assign w_rx_en        = r_ctrl[CTRL_RX_EN_BIT];

  // ---------------- Stream side ----------------
  // With rx_en low the stream is drained and discarded so the
  // receiver never stalls.
  assign s_axis_tready = w_rx_en ? ~w_full : 1'b1;
  assign w_push        = s_axis_tvalid & w_rx_en & ~w_full;
  assign w_ovr_set     = s_axis_tvalid & w_rx_en & w_full;
  assign w_ovr_clr     = w_w_hs && (r_waddr == ADDR_STAT) &&
                         w_wmask[STAT_OVERRUN_BIT] && s_axi_wdata[STAT_OVERRUN_BIT];

  // A new overrun in the same cycle as a clear must not be lost
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (w_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  irc_rx_fifo #(
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (w_push),
    .din     (s_axis_tdata),
    .pop     (w_pop),
    .dout    (w_fifo_dout),
    .count   (w_count),
    .empty   (w_empty),
    .full    (w_full)
  );

  // ---------------- Read FSM ----------------
  // The RXDR pop is tied to the ar handshake so the head captured into
  // rdata and the pop happen in the same cycle.
  assign w_pop = w_ar_hs && (s_axi_araddr[3:0] == ADDR_RXDR) && !w_empty;

  always_comb begin
    w_rdata_next = '0;
    case (s_axi_araddr[3:0])
      ADDR_CTRL: w_rdata_next = r_ctrl;
      ADDR_RXDR: begin
        if (!w_empty) begin
          w_rdata_next[RXDR_VALID_BIT] = 1'b1;
          w_rdata_next[7:0]            = w_fifo_dout;
        end
      end
      ADDR_STAT: begin
        w_rdata_next[STAT_COUNT_MSB:STAT_COUNT_LSB] = 9'(w_count);
        w_rdata_next[STAT_EMPTY_BIT]                = w_empty;
        w_rdata_next[STAT_FULL_BIT]                 = w_full;
        w_rdata_next[STAT_OVERRUN_BIT]              = r_overrun;
      end
      default: w_rdata_next = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate <= RDIDLE;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        RDIDLE: if (s_axi_arvalid) begin
          r_rdata  <= w_rdata_next;
          r_rstate <= RDDATA;
        end
        RDDATA: if (s_axi_rready) r_rstate <= RDIDLE;
        default: r_rstate <= RDIDLE;
      endcase
    end
  end

`ifdef AXI_IRCRX_IRQ_EN
  logic r_irq;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl[CTRL_IRQ_EN_BIT] & (~w_empty | r_overrun);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_axi_ircrx_control.sv
`timescale 1ns/1ps
module tb_axi_ircrx_control;

  localparam int DEPTH = 16;
  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_RXDR = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_RSVD = 4'hC;
`ifdef AXI_IRCRX_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'h0007_FFFF;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0003_FFFF;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axi_awready, s_axi_awvalid = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_wready, s_axi_wvalid = 1'b0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_bready = 1'b1;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_arready, s_axi_arvalid = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_rready = 1'b1;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [15:0] mod_m;
  logic        demod_38khz_en;
`ifdef AXI_IRCRX_IRQ_EN
  logic        irq;
`endif

  axi_ircrx_control #(
    .C_ADDR_WIDTH (32),
    .C_DATA_WIDTH (32),
    .C_FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axi_awready  (s_axi_awready),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_bready   (s_axi_bready),
    .s_axi_bresp    (s_axi_bresp),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_rready   (s_axi_rready),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .mod_m          (mod_m),
    .demod_38khz_en (demod_38khz_en)
`ifdef AXI_IRCRX_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO as a plain queue, CTRL word, sticky overrun
  logic [7:0]  m_q[$];
  logic [31:0] m_ctrl = '0;
  logic        m_ovr  = 1'b0;

  // Scoreboard of expected read responses
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s       = '0;
    s[8:0]  = 9'(m_q.size());
    s[16]   = (m_q.size() == 0);
    s[17]   = (m_q.size() == DEPTH);
    s[18]   = m_ovr;
    return s;
  endfunction

  // One stream beat offered to the model: accepted, discarded or overrun
  function automatic logic m_offer(input logic [7:0] d, input int pre_size);
    logic rdy;
    rdy = m_ctrl[17] ? (pre_size < DEPTH) : 1'b1;
    if (m_ctrl[17]) begin
      if (pre_size < DEPTH) m_q.push_back(d);
      else                  m_ovr = 1'b1;
    end
    return rdy;
  endfunction

  // Monitor: compares every completed read beat with the scoreboard head
  logic [31:0] mon_e;
  string       mon_n;
  always @(negedge aclk) begin
    if (aresetn && s_axi_rvalid && s_axi_rready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rbeat: got 0x%08h required no beat", s_axi_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check(mon_n, s_axi_rdata, mon_e);
        check({mon_n, "_rresp"}, 32'(s_axi_rresp), 32'h0);
      end
    end
  end

  task automatic axi_read(input logic [3:0] a, input bit do_push, input logic [7:0] pd,
                          input string nm);
    logic [31:0] e;
    int          pre;
    logic        rdy;
    bit          got;
    @(posedge aclk); #1;
    s_axi_araddr  = {28'h0, a};
    s_axi_arvalid = 1'b1;
    if (do_push) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pd;
    end
    @(negedge aclk);
    check({nm, "_arready"}, 32'(s_axi_arready), 32'h1);
    pre = m_q.size();
    case (a)
      A_CTRL:  e = m_ctrl;
      A_RXDR:  e = (pre != 0) ? {1'b1, 23'h0, m_q[0]} : 32'h0;
      A_STAT:  e = m_stat();
      default: e = 32'h0;
    endcase
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (a == A_RXDR && pre != 0) void'(m_q.pop_front());
    if (do_push) begin
      rdy = m_offer(pd, pre);
      check({nm, "_tready"}, 32'(s_axis_tready), 32'(rdy));
    end
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    s_axis_tvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (s_axi_rvalid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no rvalid required rvalid within 16 cycles", nm);
    end
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                           input string nm);
    bit   aw_done, w_done, b_done, hs_aw, hs_w;
    logic [31:0] m;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
    @(posedge aclk); #1;
    s_axi_awaddr  = {28'h0, a};
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = d;
    s_axi_wstrb   = st;
    s_axi_wvalid  = 1'b1;
    for (int i = 0; i < 16 && !(aw_done && w_done); i++) begin
      @(negedge aclk);
      hs_aw = s_axi_awvalid & s_axi_awready;
      hs_w  = s_axi_wvalid & s_axi_wready;
      if (hs_w) begin
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{st[b]}};
        if (a == A_CTRL) m_ctrl = ((m_ctrl & ~m) | (d & m)) & CTRL_MASK;
        if (a == A_STAT && st[2] && d[18]) m_ovr = 1'b0;
      end
      @(posedge aclk); #1;
      if (hs_aw) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (s_axi_bvalid) begin
        b_done = 1'b1;
        check({nm, "_bresp"}, 32'(s_axi_bresp), 32'h0);
        break;
      end
    end
    if (!(aw_done && w_done && b_done)) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got aw=%0d w=%0d b=%0d required all 1", nm, aw_done, w_done, b_done);
    end
    @(posedge aclk); #1;
    check({nm, "_mod_m"}, 32'(mod_m), 32'(m_ctrl[15:0]));
    check({nm, "_demod"}, 32'(demod_38khz_en), 32'(m_ctrl[16]));
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic rdy;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    @(negedge aclk);
    rdy = m_offer(d, m_q.size());
    check($sformatf("push_%02h_tready", d), 32'(s_axis_tready), 32'(rdy));
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

`ifdef AXI_IRCRX_IRQ_EN
  task automatic irq_check(input string nm);
    repeat (2) @(negedge aclk);
    check(nm, 32'(irq), 32'(m_ctrl[18] & ((m_q.size() != 0) | m_ovr)));
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;
    logic [3:0]  a;
    // ---------------- reset ----------------
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("rst_tready",  32'(s_axis_tready), 32'h1);
    check("rst_awready", 32'(s_axi_awready), 32'h1);
    check("rst_arready", 32'(s_axi_arready), 32'h1);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'h0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'h0);
    check("rst_mod_m",   32'(mod_m),         32'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    axi_read(A_CTRL, 0, 8'h0, "rst_ctrl");
    axi_read(A_STAT, 0, 8'h0, "rst_stat");
    axi_read(A_RXDR, 0, 8'h0, "rst_rxdr");

    // ---------------- basic receive ----------------
    axi_write(A_CTRL, 32'h0002_01B2, 4'hF, "wr_ctrl");
    axi_read(A_CTRL, 0, 8'h0, "rd_ctrl");
    push_byte(8'hA5);
    push_byte(8'h3C);
    axi_read(A_STAT, 0, 8'h0, "stat_cnt2");
    axi_read(A_RXDR, 0, 8'h0, "rxdr_a5");
    axi_read(A_RXDR, 0, 8'h0, "rxdr_3c");
    axi_read(A_STAT, 0, 8'h0, "stat_empty");

    // ---------------- fill past full ----------------
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    axi_read(A_STAT, 0, 8'h0, "stat_full_ovr");
    axi_write(A_STAT, 32'h0004_0000, 4'hF, "clr_ovr");
    axi_read(A_STAT, 0, 8'h0, "stat_ovr_clr");

    // Full FIFO, pop in the same cycle as an offered byte: byte refused
    axi_read(A_RXDR, 1, 8'h77, "full_pop_push");
    push_byte(8'h78);
    axi_read(A_STAT, 0, 8'h0, "stat_refill");
    for (int i = 0; i < DEPTH; i++) axi_read(A_RXDR, 0, 8'h0, $sformatf("drain_%0d", i));
    axi_write(A_STAT, 32'h0004_0000, 4'h4, "clr_ovr2");

    // Count 3, simultaneous push and pop
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    axi_read(A_RXDR, 1, 8'h99, "cnt3_pop_push");
    axi_read(A_STAT, 0, 8'h0, "stat_cnt3");
    for (int i = 0; i < 3; i++) axi_read(A_RXDR, 0, 8'h0, $sformatf("cnt3_drain_%0d", i));

    // rx_en low: bytes discarded, tready stays high
    axi_write(A_CTRL, 32'h0000_1234, 4'hF, "rx_off");
    push_byte(8'hEE);
    axi_read(A_STAT, 0, 8'h0, "stat_rx_off");

`ifdef AXI_IRCRX_IRQ_EN
    axi_write(A_CTRL, 32'h0006_0000, 4'hF, "irq_en");
    push_byte(8'h55);
    @(negedge aclk);
    check("irq_lag", 32'(irq), 32'h0);
    @(negedge aclk);
    check("irq_rise", 32'(irq), 32'h1);
    axi_read(A_RXDR, 0, 8'h0, "irq_pop");
    check("irq_fall", 32'(irq), 32'h0);
`endif

    // ---------------- randomized traffic ----------------
    for (int it = 0; it < 400; it++) begin
      n = $urandom_range(0, 9);
      if (n <= 3) begin
        push_byte(8'($urandom));
      end else if (n <= 5) begin
        axi_read(A_RXDR, 1'($urandom_range(0, 1)), 8'($urandom), "r_rxdr");
      end else if (n == 6) begin
        axi_read(A_STAT, 0, 8'h0, "r_stat");
      end else if (n == 7) begin
        axi_read(($urandom_range(0, 1) != 0) ? A_CTRL : A_RSVD, 0, 8'h0, "r_ctrl_rsvd");
      end else if (n == 8) begin
        d = $urandom;
        d[17] = ($urandom_range(0, 99) < 85);
        axi_write(A_CTRL, d, 4'($urandom_range(1, 15)), "r_wctrl");
      end else begin
        case ($urandom_range(0, 2))
          0:       a = A_STAT;
          1:       a = A_RXDR;
          default: a = A_RSVD;
        endcase
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), "r_wmisc");
      end
`ifdef AXI_IRCRX_IRQ_EN
      irq_check("r_irq");
`endif
    end

    // ---------------- reset flushes everything ----------------
    @(posedge aclk); #1;
    aresetn = 1'b0;
    m_q.delete();
    m_ctrl = '0;
    m_ovr  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    axi_read(A_STAT, 0, 8'h0, "post_rst_stat");
    axi_read(A_CTRL, 0, 8'h0, "post_rst_ctrl");
    check("post_rst_mod_m", 32'(mod_m), 32'h0);

    repeat (4) @(posedge aclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
